// File: rtl/out_mem_writer_if.sv
// Result-byte stream into the output memory writer.
// Each byte carries a filter index that selects its byte lane.
interface out_mem_writer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] in_filter;

    modport master (
        output in_valid,
        output in_data,
        output in_filter,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_filter,
        output in_ready
    );
endinterface

// File: rtl/out_mem_writer.sv
// Write-side sequencer for the per-filter output memory: places result bytes
// into byte lanes of consecutive words, then pulses the memory dump.
module out_mem_writer #(
    parameter int DEPTH = 128
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [7:0]      base_addr,
    input  logic [7:0]      out_len,
    out_mem_writer_if.slave in_if,
    output logic            mem_write,
    output logic [7:0]      mem_address,
    output logic [1:0]      mem_offset,
    output logic [7:0]      mem_data,
    output logic            mem_write_out,
    output logic            busy,
    output logic            done,
    output logic            overflow
);
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, FLUSH, DONE} state_e;

    localparam logic [8:0] DEPTH_W = 9'(DEPTH);

    state_e     state_q, state_d;
    logic [7:0] base_q, base_d;
    logic [7:0] len_q, len_d;
    logic [7:0] cnt_q [4];
    logic [7:0] cnt_d [4];
    logic       overflow_q, overflow_d;
    logic       mem_write_q, mem_write_d;
    logic [7:0] mem_address_q, mem_address_d;
    logic [1:0] mem_offset_q, mem_offset_d;
    logic [7:0] mem_data_q, mem_data_d;
    logic       mem_write_out_q, mem_write_out_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [1:0] f;
    logic [7:0] len_in;
    logic [8:0] addr_full;
    logic       all_full;

    assign f      = in_if.in_filter;
    assign len_in = ({1'b0, out_len} > DEPTH_W) ? DEPTH_W[7:0] : out_len;
    // 8-bit add first, then fold into the memory depth
    assign addr_full = {1'b0, base_q + cnt_q[f]} % DEPTH_W;

    assign in_if.in_ready = (state_q == RUN);

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        overflow_d    = overflow_q;
        mem_write_d   = 1'b0;
        mem_address_d = mem_address_q;
        mem_offset_d  = mem_offset_q;
        mem_data_d    = mem_data_q;
        all_full      = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    base_d = base_addr;
                    len_d  = len_in;
                    for (int i = 0; i < 4; i++) cnt_d[i] = '0;
                    overflow_d = 1'b0;
                    state_d    = (len_in == 8'd0) ? FLUSH : RUN;
                end
            end
            RUN: begin
                if (in_if.in_valid) begin
                    if (cnt_q[f] == len_q) begin
                        overflow_d = 1'b1;
                    end else begin
                        mem_write_d   = 1'b1;
                        mem_address_d = addr_full[7:0];
                        mem_offset_d  = f;
                        mem_data_d    = in_if.in_data;
                        cnt_d[f]      = cnt_q[f] + 8'd1;
                    end
                end
                for (int i = 0; i < 4; i++) begin
                    if (cnt_d[i] != len_q) all_full = 1'b0;
                end
                if (all_full) state_d = DRAIN;
            end
            DRAIN:   state_d = FLUSH;
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        mem_write_out_d = (state_d == FLUSH);
        done_d          = (state_d == DONE);
        busy_d          = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            base_q          <= '0;
            len_q           <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            overflow_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_offset_q    <= '0;
            mem_data_q      <= '0;
            mem_write_out_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            base_q          <= base_d;
            len_q           <= len_d;
            cnt_q           <= cnt_d;
            overflow_q      <= overflow_d;
            mem_write_q     <= mem_write_d;
            mem_address_q   <= mem_address_d;
            mem_offset_q    <= mem_offset_d;
            mem_data_q      <= mem_data_d;
            mem_write_out_q <= mem_write_out_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    assign mem_write     = mem_write_q;
    assign mem_address   = mem_address_q;
    assign mem_offset    = mem_offset_q;
    assign mem_data      = mem_data_q;
    assign mem_write_out = mem_write_out_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign overflow      = overflow_q;
endmodule

// File: tb/tb_out_mem_writer.sv
// Randomized bench for out_mem_writer against a per-filter counting model.
// Expected writes are queued at accept time and matched as they appear.
module tb_out_mem_writer;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] base_addr = '0;
    logic [7:0] out_len = '0;
    logic       mem_write, mem_write_out, busy, done, overflow;
    logic [7:0] mem_address, mem_data;
    logic [1:0] mem_offset;

    out_mem_writer_if bus();

    out_mem_writer #(.DEPTH(128)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .base_addr(base_addr),
        .out_len(out_len),
        .in_if(bus.slave),
        .mem_write(mem_write),
        .mem_address(mem_address),
        .mem_offset(mem_offset),
        .mem_data(mem_data),
        .mem_write_out(mem_write_out),
        .busy(busy),
        .done(done),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // model of one frame
    int          m_base, m_len;
    int          m_cnt [4];
    bit          m_run, m_ovf;
    logic [17:0] exp_q [$];
    int          end_cyc;
    int          wo_n = 0, done_n = 0, wo_cyc = 0, done_cyc = 0;
    int          w0, d0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (mem_write) begin
                if (exp_q.size() == 0)
                    chk("spurious_write", 32'(mem_write), 0);
                else
                    chk("write", {mem_address, mem_offset, mem_data},
                        exp_q.pop_front());
            end
            if (mem_write && mem_write_out)
                chk("wo_excl", 32'(mem_write_out), 0);
            if (mem_write_out) begin
                wo_n++;
                wo_cyc = cyc;
            end
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic bit all_full();
        for (int i = 0; i < 4; i++)
            if (m_cnt[i] != m_len) return 1'b0;
        return 1'b1;
    endfunction

    task automatic do_reset(input string tag);
        reset = 1'b1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        chk({tag, "_ready"}, bus.in_ready, 0);
        chk({tag, "_wr"}, mem_write, 0);
        chk({tag, "_addr"}, mem_address, 0);
        chk({tag, "_off"}, mem_offset, 0);
        chk({tag, "_data"}, mem_data, 0);
        chk({tag, "_wo"}, mem_write_out, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_ovf"}, overflow, 0);
        exp_q.delete();
        m_run = 1'b0;
        m_ovf = 1'b0;
        reset = 1'b0;
    endtask

    task automatic begin_frame(input int b, input int l);
        w0 = wo_n;
        d0 = done_n;
        start = 1'b1;
        base_addr = 8'(b);
        out_len = 8'(l);
        m_base = b;
        m_len = (l > 128) ? 128 : l;
        m_cnt = '{default: 0};
        m_ovf = 1'b0;
        m_run = (m_len > 0);
        tick();
        start = 1'b0;
        if (m_len == 0) end_cyc = cyc - 1;
        chk("busy_start", busy, 1);
        chk("ovf_clear", overflow, 0);
    endtask

    task automatic send(input logic [1:0] f, input logic [7:0] d,
                        input bit v, input bit st);
        bit fin;
        fin = 1'b0;
        bus.in_valid = v;
        bus.in_filter = f;
        bus.in_data = d;
        start = st;
        base_addr = 8'($urandom);
        chk("in_ready", bus.in_ready, m_run);
        if (v && m_run) begin
            if (m_cnt[f] < m_len) begin
                exp_q.push_back({8'((m_base + m_cnt[f]) % 128), f, d});
                m_cnt[f]++;
            end else begin
                m_ovf = 1'b1;
            end
            if (all_full()) begin
                m_run = 1'b0;
                fin = 1'b1;
            end
        end
        tick();
        start = 1'b0;
        bus.in_valid = 1'b0;
        if (fin) end_cyc = cyc;
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic end_frame();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 40 && done_n == d0; i++) tick();
        chk("done_cnt", done_n - d0, 1);
        chk("wo_cnt", wo_n - w0, 1);
        chk("wo_cyc", wo_cyc - end_cyc, 1);
        chk("done_cyc", done_cyc - end_cyc, 2);
        chk("busy_end", busy, 0);
        chk("pending", exp_q.size(), 0);
        chk("ovf_end", overflow, m_ovf);
    endtask

    task automatic run_list(input logic [9:0] q [$], input int st_at,
                            input bit gaps);
        foreach (q[i]) begin
            if (gaps && $urandom_range(0, 3) == 0)
                send(2'd0, 8'd0, 1'b0, 1'b0);
            send(q[i][9:8], q[i][7:0], 1'b1, i == st_at);
        end
    endtask

    initial begin
        logic [9:0] q [$];
        logic [9:0] tmp;
        int l, j;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_filter = '0;

        do_reset("rst");

        // basic frame, with a start pulse mid-run that must be ignored
        begin_frame(8'h10, 2);
        q = '{10'h0A1, 10'h1B1, 10'h2C1, 10'h3D1,
              10'h0A2, 10'h1B2, 10'h2C2, 10'h3D2};
        run_list(q, 3, 1'b0);
        end_frame();

        // interleave and wrap: all f2 first
        begin_frame(126, 3);
        q = '{10'h211, 10'h212, 10'h213, 10'h021, 10'h131, 10'h341,
              10'h022, 10'h132, 10'h342, 10'h023, 10'h133, 10'h343};
        run_list(q, -1, 1'b0);
        end_frame();

        // overflow on f0
        begin_frame(8'h40, 1);
        q = '{10'h055, 10'h066, 10'h177, 10'h288, 10'h399};
        run_list(q, -1, 1'b0);
        end_frame();
        chk("ovf_sticky", overflow, 1);

        // in_valid while idle is not taken
        for (int i = 0; i < 3; i++) send(2'(i), 8'hEE, 1'b1, 1'b0);

        // empty frame
        begin_frame(8'h05, 0);
        end_frame();

        // oversize length clamps
        begin_frame(8'h33, 200);
        q.delete();
        for (int n = 0; n < 129; n++)
            for (int f = 0; f < 4; f++)
                q.push_back({2'(f), 8'($urandom)});
        run_list(q, -1, 1'b0);
        end_frame();

        // reset in the middle of a frame
        begin_frame(8'h20, 4);
        send(2'd0, 8'h01, 1'b1, 1'b0);
        send(2'd1, 8'h02, 1'b1, 1'b0);
        send(2'd2, 8'h03, 1'b1, 1'b0);
        send(2'd0, 8'h00, 1'b0, 1'b0);
        do_reset("midrst");
        for (int i = 0; i < 5; i++) tick();
        chk("midrst_nowo", wo_n - w0, 0);
        chk("midrst_nodone", done_n - d0, 0);

        // random frames with gaps, extra bytes and stray starts
        for (int t = 0; t < 40; t++) begin
            l = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
            begin_frame($urandom_range(0, 255), l);
            q.delete();
            for (int f = 0; f < 4; f++)
                for (int n = 0; n < l; n++)
                    q.push_back({2'(f), 8'($urandom)});
            for (int k = 0; k < 2; k++)
                if (l > 0 && $urandom_range(0, 1) == 1)
                    q.push_back({2'($urandom), 8'($urandom)});
            for (int i = q.size() - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = q[i];
                q[i] = q[j];
                q[j] = tmp;
            end
            run_list(q, $urandom_range(0, 8), 1'b1);
            end_frame();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
